tia_hphase_gen: RTL and testbench
=================================

// Module: tia_hphase_gen
// PURPOSE
//  Horizontal two-phase strobe generator and 6-bit polynomial line counter.
//  Produces the non-overlapping s1/s2 strobes consumed by downstream DL latches.
//  Advances the TIA horizontal LFSR once per 4-clock phase period and decodes
//  line start and HSYNC from it; honours an RSYNC strobe. One line = 228 clk.
// PARAMETERS
//  WRAP_PAT   6'b001010  count value after which counter returns to 6'b000000
//  HS_SET_PAT 6'b001111  count value at whose s2 edge hsync sets
//  HS_CLR_PAT 6'b111011  count value at whose s2 edge hsync clears
// PORTS
//  clk         in   1  color clock; single clock domain
//  r           in   1  reset, asynchronous, active-high
//  rsync       in   1  sync reset request, 1-clk strobe, sampled every clk
//  s1          out  1  phase-1 strobe, high 1 clk of every 4
//  s2          out  1  phase-2 strobe, high 1 clk of every 4, 2 clk after s1
//  hcount      out  6  current LFSR count
//  line_start  out  1  high during s1 while hcount==000000
//  hsync       out  1  registered horizontal sync level
// BEHAVIOUR
//  - Reset (r=1, async): phase reg p=2'b10, hcount=0, hsync=0, rsync_pend=0.
//    s1, s2 and line_start forced 0 while r=1.
//  - Phase reg p is a 2-bit Gray counter: 00->01->11->10->00, one step per clk.
//    s1 = ~r & (p==00); s2 = ~r & (p==11); never both high; 1-clk gap between.
//  - The first rising clk after r falls loads p=00, so s1 is high in cycle 1.
//    s2 is high in cycle 3.
//  - Counter step, taken on the clk edge ending an s2 cycle:
//    - rsync_pend=1: hcount<=000000, rsync_pend<=0.
//    - else hcount==WRAP_PAT: hcount<=000000.
//    - else hcount<={hcount[4:0], ~(hcount[5]^hcount[4])}.
//  - Default sequence from 0: 000000,000001,000011,000111,001111,011111,...
//    It reaches 001010 at step 56, giving 57 states x 4 clk = 228 clk per line.
//  - hcount is stable across s1 and s2 of a period; it changes only after s2.
//  - rsync: any clk with rsync=1 sets rsync_pend, held until the next s2 edge.
//    That edge zeroes hcount, and line_start fires at the following s1.
//    Multiple rsync pulses within one period are equivalent to one.
//    rsync in the s2 cycle itself is honoured at that same edge.
//    rsync coinciding with the wrap gives the same result (hcount=0).
//  - hsync, updated only on s2 edges, using hcount before it steps:
//    - hcount==HS_SET_PAT -> 1; hcount==HS_CLR_PAT -> 0; else hold.
//    - With defaults, hsync rises at the end of state 4's s2 and falls at the
//      end of state 8's s2: 16 clk high per line.
//    - rsync does not touch hsync directly; hsync holds until the next decode.
//  - line_start combinational from s1 and hcount; 1 clk wide, once per line.
//  - r asserted mid-line: all state returns to reset values immediately.
//    Restart after release is identical to power-up.
// TESTING
//  1 Release r, free-run 1000 clk -> s1 cycles 1,5,9..., s2 cycles 3,7,11...;
//    s1&s2 never 1; hcount changes only on the clk after s2.
//  2 Free-run from reset -> hcount follows 000000,000001,000011,000111,001111,
//    011111,111110; line_start period exactly 228 clk; 57 distinct values.
//  3 Free-run -> hsync rises 1 clk after s2 with hcount=001111, stays high 16 clk,
//    falls after s2 with hcount=111011; once per 228 clk.
//  4 Pulse rsync 1 clk while hcount=110011 (mid-line) -> hcount=000000 after the
//    next s2; line_start 2 clk later; next line_start 228 clk after that.
//  5 rsync in the s2 cycle where hcount=001010 (wrap), and rsync twice in one
//    period -> single reset to 0; period after is 228 clk.
//  6 Assert r for 3 clk while hsync=1 at hcount=011111 -> s1=s2=hsync=0 and
//    hcount=0 immediately (async); post-release sequence matches test 1.

Source files
------------

// File: rtl/tia_hphase_gen.sv
// tia_hphase_gen: two-phase s1/s2 strobe generator with the 6-bit horizontal
// LFSR line counter, line-start and HSYNC decodes, and RSYNC handling.
// One period is 4 clk, and one line is 57 periods (228 clk).
module tia_hphase_gen #(
    parameter logic [5:0] WRAP_PAT   = 6'b001010,
    parameter logic [5:0] HS_SET_PAT = 6'b001111,
    parameter logic [5:0] HS_CLR_PAT = 6'b111011
) (
    input  logic       clk,
    input  logic       r,
    input  logic       rsync,
    output logic       s1,
    output logic       s2,
    output logic [5:0] hcount,
    output logic       line_start,
    output logic       hsync
);

    // Gray-coded phase, so only one bit changes per clk.
    // The reset value PH_G2 makes the first clk after release land on PH_S1.
    typedef enum logic [1:0] {
        PH_S1 = 2'b00,
        PH_G1 = 2'b01,
        PH_S2 = 2'b11,
        PH_G2 = 2'b10
    } phase_t;

    phase_t     phase, phase_nxt;
    logic       rsync_pend;
    logic       do_zero;
    logic [5:0] hcount_nxt;

    // Phase register.
    always_ff @(posedge clk or posedge r) begin
        if (r) phase <= PH_G2;
        else   phase <= phase_nxt;
    end

    // Phase sequencing: 00 -> 01 -> 11 -> 10 -> 00.
    always_comb begin
        phase_nxt = PH_S1;
        case (phase)
            PH_S1:   phase_nxt = PH_G1;
            PH_G1:   phase_nxt = PH_S2;
            PH_S2:   phase_nxt = PH_G2;
            PH_G2:   phase_nxt = PH_S1;
            default: phase_nxt = PH_S1;
        endcase
    end

    // Strobes are gated by r so they drop as soon as reset is asserted.
    assign s1 = ~r & (phase == PH_S1);
    assign s2 = ~r & (phase == PH_S2);
    assign line_start = s1 & (hcount == 6'b000000);

    // An rsync that arrives during the s2 cycle is folded into that cycle's step.
    // The wrap condition also forces zero, so the two cases cannot conflict.
    always_comb begin
        do_zero    = rsync_pend | rsync | (hcount == WRAP_PAT);
        hcount_nxt = do_zero ? 6'b000000
                             : {hcount[4:0], ~(hcount[5] ^ hcount[4])};
    end

    // Counter, hsync and rsync_pend advance only on the edge that ends s2.
    // hsync decodes the pre-step count.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            hcount     <= 6'b000000;
            hsync      <= 1'b0;
            rsync_pend <= 1'b0;
        end else if (phase == PH_S2) begin
            hcount     <= hcount_nxt;
            rsync_pend <= 1'b0;
            if (hcount == HS_SET_PAT)      hsync <= 1'b1;
            else if (hcount == HS_CLR_PAT) hsync <= 1'b0;
        end else if (rsync) begin
            rsync_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tia_hphase_gen.sv
// Testbench for tia_hphase_gen: a period/line-level reference model, with
// randomized rsync stimulus and per-scenario checking tasks.
module tb_tia_hphase_gen;

    localparam logic [5:0] WRAP   = 6'b001010;
    localparam logic [5:0] HS_SET = 6'b001111;
    localparam logic [5:0] HS_CLR = 6'b111011;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       rsync = 1'b0;
    logic       s1, s2, line_start, hsync;
    logic [5:0] hcount;

    int npass = 0;
    int ntotal = 0;

    tia_hphase_gen dut (
        .clk        (clk),
        .r          (r),
        .rsync      (rsync),
        .s1         (s1),
        .s2         (s2),
        .hcount     (hcount),
        .line_start (line_start),
        .hsync      (hsync)
    );

    always #5 clk = ~clk;

    // Reference model.
    // m_slot is the clk position within a 4-clk period:
    //   0 = s1, 2 = s2, 1 and 3 = gaps.
    // The count advances by the polynomial rule once per period.
    int         m_slot;
    logic [5:0] m_cnt;
    logic       m_hs, m_pend;

    function automatic logic [5:0] poly_next(input logic [5:0] c);
        int v;
        v = (int'(c) * 2) % 64;
        if (((c >> 5) & 1) == ((c >> 4) & 1)) v = v + 1;
        return 6'(v);
    endfunction

    always @(posedge clk or posedge r) begin
        if (r) begin
            m_slot <= 3;
            m_cnt  <= '0;
            m_hs   <= 1'b0;
            m_pend <= 1'b0;
        end else begin
            m_slot <= (m_slot + 1) % 4;
            if (m_slot == 2) begin
                if (m_cnt == HS_SET)      m_hs <= 1'b1;
                else if (m_cnt == HS_CLR) m_hs <= 1'b0;
                m_cnt  <= (m_pend || rsync || m_cnt == WRAP) ? 6'd0 : poly_next(m_cnt);
                m_pend <= 1'b0;
            end else if (rsync) begin
                m_pend <= 1'b1;
            end
        end
    end

    logic [9:0] m_vec;
    assign m_vec = {!r && m_slot == 0, !r && m_slot == 2,
                    !r && m_slot == 0 && m_cnt == 6'd0, m_hs, m_cnt};

    logic [9:0] d_vec;
    assign d_vec = {s1, s2, line_start, hsync, hcount};

    task automatic release_reset();
        @(negedge clk);
        rsync = 1'b0;
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        r = 1'b1;
        rsync = 1'b0;
        @(negedge clk);
        ntotal++;
        if (d_vec !== 10'd0) $display("FAIL reset_state: got %b need 0", d_vec);
        else npass++;
        r = 1'b0;
    endtask

    task automatic test_freerun();
        int last_ls = -1;
        int rise = -1;
        logic [5:0] prev_cnt;
        logic prev_s2 = 1'b0;
        logic prev_hs = 1'b0;
        release_reset();
        prev_cnt = 6'd0;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            ntotal++;
            if (d_vec !== m_vec) $display("FAIL freerun_model n=%0d: got %b need %b", n, d_vec, m_vec);
            else npass++;
            ntotal++;
            if ({s1, s2} !== {1'(n % 4 == 1), 1'(n % 4 == 3)})
                $display("FAIL strobe_timing n=%0d: got s1s2=%b%b", n, s1, s2);
            else npass++;
            if (hcount !== prev_cnt) begin
                ntotal++;
                if (!prev_s2) $display("FAIL hcount_change n=%0d: changed without s2", n);
                else npass++;
            end
            if (line_start) begin
                if (last_ls >= 0) begin
                    ntotal++;
                    if (n - last_ls != 228) $display("FAIL line_period: got %0d need 228", n - last_ls);
                    else npass++;
                end
                last_ls = n;
            end
            if (hsync && !prev_hs) begin
                rise = n;
                ntotal++;
                if (prev_cnt !== HS_SET) $display("FAIL hsync_rise_cnt: got %b need %b", prev_cnt, HS_SET);
                else npass++;
            end
            if (!hsync && prev_hs && rise >= 0) begin
                ntotal++;
                if (n - rise != 16) $display("FAIL hsync_width: got %0d need 16", n - rise);
                else npass++;
            end
            prev_cnt = hcount;
            prev_s2 = s2;
            prev_hs = hsync;
        end
    endtask

    task automatic test_sequence();
        logic [5:0] exp7 [7];
        logic [5:0] seen [58];
        int nseen = 0;
        int distinct = 0;
        exp7 = '{6'd0, 6'd1, 6'd3, 6'd7, 6'd15, 6'd31, 6'd62};
        release_reset();
        for (int n = 0; n < 58 * 4 && nseen < 58; n++) begin
            @(negedge clk);
            if (s1) begin
                seen[nseen] = hcount;
                nseen++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            ntotal++;
            if (seen[i] !== exp7[i]) $display("FAIL seq_%0d: got %b need %b", i, seen[i], exp7[i]);
            else npass++;
        end
        for (int i = 0; i < 57; i++) begin
            bit dup = 0;
            for (int j = 0; j < i; j++) if (seen[j] == seen[i]) dup = 1;
            if (!dup) distinct++;
        end
        ntotal++;
        if (distinct != 57) $display("FAIL seq_distinct: got %0d need 57", distinct);
        else npass++;
        ntotal++;
        if (seen[56] !== WRAP || seen[57] !== 6'd0)
            $display("FAIL seq_wrap: got %b,%b need %b,000000", seen[56], seen[57], WRAP);
        else npass++;
    endtask

    task automatic test_rsync_mid();
        bit found = 0;
        int n_s2 = -1;
        int n_ls = -1;
        int n_ls2 = -1;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (hcount == 6'b110011) found = 1;
        end
        ntotal++;
        if (!found) begin
            $display("FAIL rsync_mid_wait: hcount 110011 not seen");
            return;
        end
        npass++;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rsync = 1'b1;
        for (int n = 0; n < 500 && n_ls2 < 0; n++) begin
            @(negedge clk);
            rsync = 1'b0;
            if (s2 && n_s2 < 0) n_s2 = n;
            ntotal++;
            if (d_vec !== m_vec) $display("FAIL rsync_mid_model n=%0d: got %b need %b", n, d_vec, m_vec);
            else npass++;
            if (line_start) begin
                if (n_ls < 0) n_ls = n;
                else n_ls2 = n;
            end
        end
        ntotal++;
        if (n_ls - n_s2 != 2) $display("FAIL rsync_mid_latency: got %0d need 2", n_ls - n_s2);
        else npass++;
        ntotal++;
        if (n_ls2 - n_ls != 228) $display("FAIL rsync_mid_period: got %0d need 228", n_ls2 - n_ls);
        else npass++;
    endtask

    task automatic test_rsync_wrap();
        bit found = 0;
        int n_ls = -1;
        int n_ls2 = -1;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (hcount == WRAP && s2) found = 1;
        end
        ntotal++;
        if (!found) begin
            $display("FAIL rsync_wrap_wait: wrap s2 not seen");
            return;
        end
        npass++;
        rsync = 1'b1;
        @(negedge clk);
        rsync = 1'b0;
        ntotal++;
        if (hcount !== 6'd0 || d_vec !== m_vec) $display("FAIL rsync_wrap_zero: got %b need 000000", hcount);
        else npass++;
        // Two pulses in one period, starting right after an s1.
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (s1 && hcount == 6'd31) break;
        end
        rsync = 1'b1;
        @(negedge clk);
        rsync = 1'b0;
        @(negedge clk);
        rsync = 1'b1;
        for (int n = 0; n < 500 && n_ls2 < 0; n++) begin
            @(negedge clk);
            rsync = 1'b0;
            ntotal++;
            if (d_vec !== m_vec) $display("FAIL rsync_double_model n=%0d: got %b need %b", n, d_vec, m_vec);
            else npass++;
            if (line_start) begin
                if (n_ls < 0) n_ls = n;
                else n_ls2 = n;
            end
        end
        ntotal++;
        if (n_ls2 - n_ls != 228) $display("FAIL rsync_double_period: got %0d need 228", n_ls2 - n_ls);
        else npass++;
    endtask

    task automatic test_random_rsync();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rsync = ($urandom_range(0, 39) == 0);
            ntotal++;
            if (d_vec !== m_vec) $display("FAIL random_rsync n=%0d: got %b need %b", n, d_vec, m_vec);
            else npass++;
        end
        rsync = 1'b0;
    endtask

    task automatic test_async_reset();
        bit found = 0;
        release_reset();
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (hcount == 6'b011111 && hsync) found = 1;
        end
        ntotal++;
        if (!found) begin
            $display("FAIL async_wait: hcount 011111 with hsync not seen");
            return;
        end
        npass++;
        #1 r = 1'b1;
        #1;
        ntotal++;
        if (d_vec !== 10'd0) $display("FAIL async_immediate: got %b need 0", d_vec);
        else npass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ntotal++;
            if (d_vec !== 10'd0) $display("FAIL async_hold k=%0d: got %b need 0", k, d_vec);
            else npass++;
        end
        r = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            ntotal++;
            if ({s1, s2} !== {1'(n % 4 == 1), 1'(n % 4 == 3)} || d_vec !== m_vec)
                $display("FAIL async_restart n=%0d: got %b need %b", n, d_vec, m_vec);
            else npass++;
        end
    endtask

    initial begin
        #1 r = 1'b1;
        test_reset();
        test_freerun();
        test_sequence();
        test_rsync_mid();
        test_rsync_wrap();
        test_random_rsync();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
